pkt_framer: RTL and testbench
=============================

# pkt_framer

Parametrised multi-channel packet framer for the DSP data path. It arbitrates round-robin among N_CH streaming sources and emits fixed-length packets on one output stream. Each packet is one header word {address, magic number} followed by PKT_LEN data words from the granted channel. It sits between the per-channel DSP outputs and the link/transmit interface, and supports valid/ready back-pressure on both sides.

## Interface
- DATA_W, 32, data and header word width
- ADDR_W, 5, channel address field width
- MAGIC_W, 15, magic field width; ADDR_W+MAGIC_W <= DATA_W
- MAGIC, 15'h0AFA, header magic value
- N_CH, 4, number of input channels (>= 1)
- PKT_LEN, 16, data words per packet (>= 1)

- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- ch_addr  in  N_CH*ADDR_W  per-channel address; channel i uses slice i; must be static during traffic
- s_data  in  N_CH*DATA_W  per-channel input data, slice i
- s_valid  in  N_CH  per-channel input valid
- s_ready  out  N_CH  per-channel input ready
- m_data  out  DATA_W  output word
- m_valid  out  1  output valid
- m_ready  in  1  output ready
- m_sop  out  1  first word of packet (the header)
- m_eop  out  1  last word of packet

## Operation
- The outputs m_data, m_valid, m_sop and m_eop are registered as one output stage.
- load_en = !m_valid || m_ready. The output register changes only when load_en is 1.
- Header word: {zeros, ch_addr[g], MAGIC}. Bits [MAGIC_W-1:0] hold MAGIC. The next ADDR_W bits hold the address. The remaining upper bits are zero.
- State machine states are IDLE, DATA and TRL (TRL exists only when the trailer macro is set).
- IDLE:
  - s_ready is all 0.
  - If load_en is 1 and any s_valid is 1: pick grant g, the first requesting channel after last_grant in circular order. Load the header with m_sop=1 and m_eop=0. Set cnt=0 and go to DATA.
  - If load_en is 1 and no s_valid is 1: set m_valid=0.
- DATA:
  - s_ready[g] = load_en. All other s_ready bits are 0.
  - On a transfer (s_valid[g] && s_ready[g]): load s_data[g], set m_sop=0, m_eop=(cnt==PKT_LEN-1) when the trailer is disabled, and increment cnt.
  - On the last word: set last_grant=g, then go to IDLE (trailer disabled) or TRL (trailer enabled).
  - If load_en is 1 and s_valid[g] is 0: set m_valid=0. This is a bubble, and the packet continues.
- s_ready depends only on state, grant and load_en, never on s_valid.
- Arbitration happens only at packet boundaries. A granted channel keeps the grant until its packet ends, regardless of how the other channels request.
- cnt width is $clog2(PKT_LEN+1). cnt never wraps inside a packet.
- Reset (reset==0 at a clock edge):
  - m_data=0, m_valid=0, m_sop=0, m_eop=0, state=IDLE, cnt=0, last_grant=N_CH-1 (channel 0 has first priority), checksum=0.
  - A packet in progress is dropped with no eop. Words held in the output register are discarded.

## Timing
- A header is loaded in the first cycle in which a request is present and load_en is 1. It appears on m_data the following cycle.
- Data latency from s_data to m_data is 1 cycle.
- Back-to-back packets have no bubble. The next header loads in the cycle the last word (data or trailer) is accepted downstream, provided a request is present.
- While m_valid && !m_ready, m_data, m_sop and m_eop hold stable and every s_ready is 0.
- With m_ready held at 1 and s_valid held at 1, one packet takes PKT_LEN+1 cycles, or PKT_LEN+2 with the trailer.

## Configuration
- PKT_FRAMER_TRAILER_EN defined:
  - A checksum register is cleared when the header loads and XOR-accumulates every data word transferred.
  - After the last data word the block enters TRL. In TRL, s_ready is 0. When load_en is 1, it loads the checksum with m_eop=1, then goes to IDLE.
  - The packet is PKT_LEN+2 words, and m_eop is on the trailer.
- Not defined: no TRL state and no checksum logic. The packet is PKT_LEN+1 words, and m_eop is on the last data word.

## Structure
- Package pkt_framer_pkg contains:
  - the state enum
  - the MAGIC default
  - the function make_header(addr) that builds the header word
- Sub-module rr_arbiter, parametrised by N_CH. Inputs: req, last_grant. Outputs: grant index, any_req. It is purely combinational.

## Test plan
- Single channel: N_CH=4, PKT_LEN=4, ch1 addr 5'h03, data 1,2,3,4, m_ready=1 → outputs 0x00018AFA (sop), 1, 2, 3, 4 (eop on 4) in 5 consecutive cycles.
- All channels hold s_valid=1 → grant order 0,1,2,3,0, with no idle cycle between packets; each header carries the matching address.
- m_ready driven by a 50% random pattern → the output sequence is identical to the m_ready=1 case, and m_data is stable whenever m_valid && !m_ready.
- ch2 drops s_valid for 3 cycles mid-packet → m_valid is 0 for 3 cycles, the packet resumes on ch2, and s_ready of the other channels stays 0 throughout.
- reset=0 for one cycle during the 2nd data word → m_valid=0 the next cycle; the next packet starts with a header from channel 0, if channel 0 is requesting.
- PKT_FRAMER_TRAILER_EN set, data 1,2,3,4 → trailer 0x00000004 follows the data, m_eop is only on the trailer, and the packet is 6 words.

Source files
------------

// File: rtl/pkt_framer_pkg.sv
// rtl/pkt_framer_pkg.sv - shared state type, magic default and header builder for pkt_framer
package pkt_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TRL  = 2'd2
  } state_t;

  localparam int MAGIC_W_DEF = 15;
  localparam logic [MAGIC_W_DEF-1:0] MAGIC_DEF = 15'h0AFA;
  localparam int HDR_MAX_W = 64;

  // Header layout {zeros, addr, magic}; callers truncate to their own word width.
  function automatic logic [HDR_MAX_W-1:0] make_header(input logic [HDR_MAX_W-1:0] addr,
                                                       input logic [HDR_MAX_W-1:0] magic,
                                                       input int magic_w);
    return (addr << magic_w) | magic;
  endfunction

endpackage

// File: rtl/pkt_framer_rr_arbiter.sv
// rtl/pkt_framer_rr_arbiter.sv - combinational round-robin pick of the first requester after last_grant
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  int w_dist;
  int w_best;

  // Distance 0 is the channel right after last_grant; the smallest requesting distance wins.
  always_comb begin
    grant  = '0;
    w_best = N_CH;
    w_dist = 0;
    for (int c = 0; c < N_CH; c++) begin
      w_dist = (c + N_CH - 1 - int'(last_grant)) % N_CH;
      if (req[c] && (w_dist < w_best)) begin
        w_best = w_dist;
        grant  = IDX_W'(c);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/pkt_framer.sv
// rtl/pkt_framer.sv - round-robin multi-channel packet framer; PKT_FRAMER_TRAILER_EN adds an XOR checksum trailer
module pkt_framer
  import pkt_framer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int MAGIC_W = 15,
  parameter logic [MAGIC_W-1:0] MAGIC = MAGIC_W'(MAGIC_DEF),
  parameter int N_CH    = 4,
  parameter int PKT_LEN = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*DATA_W-1:0]   s_data,
  input  logic [N_CH-1:0]          s_valid,
  output logic [N_CH-1:0]          s_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_sop,
  output logic                     m_eop
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(PKT_LEN + 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_grant;
  logic [IDX_W-1:0]  r_last_grant;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_valid;
  logic              r_m_sop;
  logic              r_m_eop;
`ifdef PKT_FRAMER_TRAILER_EN
  logic [DATA_W-1:0] r_csum;
`endif

  logic              w_load_en;
  logic              w_any_req;
  logic              w_sel_valid;
  logic              w_last;
  logic [IDX_W-1:0]  w_arb_grant;
  logic [ADDR_W-1:0] w_arb_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [DATA_W-1:0] w_hdr;

  assign w_load_en = !r_m_valid || m_ready;
  assign w_last    = (r_cnt == CNT_W'(PKT_LEN - 1));
  assign w_hdr     = DATA_W'(make_header(HDR_MAX_W'(w_arb_addr), HDR_MAX_W'(MAGIC), MAGIC_W));

  rr_arbiter #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
    .req        (s_valid),
    .last_grant (r_last_grant),
    .grant      (w_arb_grant),
    .any_req    (w_any_req)
  );

  // s_ready is a function of state, grant and load_en only, never of s_valid.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_arb_addr  = '0;
    s_ready     = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (r_grant == IDX_W'(c)) begin
        w_sel_data  = s_data[c*DATA_W +: DATA_W];
        w_sel_valid = s_valid[c];
        s_ready[c]  = (r_state == ST_DATA) && w_load_en;
      end
      if (w_arb_grant == IDX_W'(c)) begin
        w_arb_addr = ch_addr[c*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(N_CH - 1);
      r_cnt        <= '0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_sop      <= 1'b0;
      r_m_eop      <= 1'b0;
`ifdef PKT_FRAMER_TRAILER_EN
      r_csum       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load_en) begin
            if (w_any_req) begin
              r_m_data  <= w_hdr;
              r_m_valid <= 1'b1;
              r_m_sop   <= 1'b1;
              r_m_eop   <= 1'b0;
              r_grant   <= w_arb_grant;
              r_cnt     <= '0;
`ifdef PKT_FRAMER_TRAILER_EN
              r_csum    <= '0;
`endif
              r_state   <= ST_DATA;
            end else begin
              r_m_valid <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (w_load_en) begin
            if (w_sel_valid) begin
              r_m_data  <= w_sel_data;
              r_m_valid <= 1'b1;
              r_m_sop   <= 1'b0;
              r_cnt     <= r_cnt + CNT_W'(1);
`ifdef PKT_FRAMER_TRAILER_EN
              r_m_eop   <= 1'b0;
              r_csum    <= r_csum ^ w_sel_data;
`else
              r_m_eop   <= w_last;
`endif
              if (w_last) begin
                r_last_grant <= r_grant;
`ifdef PKT_FRAMER_TRAILER_EN
                r_state      <= ST_TRL;
`else
                r_state      <= ST_IDLE;
`endif
              end
            end else begin
              r_m_valid <= 1'b0;
            end
          end
        end
`ifdef PKT_FRAMER_TRAILER_EN
        ST_TRL: begin
          if (w_load_en) begin
            r_m_data  <= r_csum;
            r_m_valid <= 1'b1;
            r_m_sop   <= 1'b0;
            r_m_eop   <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_sop   = r_m_sop;
  assign m_eop   = r_m_eop;

endmodule

// File: tb/tb_pkt_framer.sv
// tb/tb_pkt_framer.sv - randomized self-checking bench for pkt_framer against a packet-level model
module tb_pkt_framer;

  localparam int N_CH    = 4;
  localparam int PKT_LEN = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
`ifdef PKT_FRAMER_TRAILER_EN
  localparam bit TRL = 1'b1;
`else
  localparam bit TRL = 1'b0;
`endif
  localparam int PKT_WORDS = PKT_LEN + 1 + (TRL ? 1 : 0);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_CH*ADDR_W-1:0] ch_addr;
  logic [N_CH*DATA_W-1:0] s_data;
  logic [N_CH-1:0]        s_valid;
  logic [N_CH-1:0]        s_ready;
  logic [DATA_W-1:0]      m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_sop;
  logic                   m_eop;

  always #5 clk = ~clk;

  pkt_framer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAGIC_W(15), .MAGIC(15'h0AFA),
    .N_CH(N_CH), .PKT_LEN(PKT_LEN)
  ) dut (
    .clk(clk), .reset(reset), .ch_addr(ch_addr), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop)
  );

  int total = 0;
  int bad = 0;

  logic [31:0]     src_mem [N_CH][1024];
  int              idx [N_CH];
  int              lim [N_CH];
  int              exp_seq [N_CH];
  logic [N_CH-1:0] hs = '0;
  logic [N_CH-1:0] p_req = '0;
  logic [N_CH-1:0] v_valid = '0;
  bit              v_ready = 1'b1;
  bit              v_reset = 1'b1;
  bit              p_stall = 1'b0;
  bit              p_reset = 1'b0;
  bit              armed = 1'b0;
  logic [31:0]     p_data;
  logic            p_sop;
  logic            p_eop;

  int          m_last = N_CH - 1;
  int          m_pos = 0;
  int          m_ch = 0;
  logic [31:0] m_csum = '0;
  int          cyc = 0;
  int          n_idle = 0;

  logic [31:0] cap_d[$];
  logic        cap_s[$];
  logic        cap_e[$];
  int          cap_c[$];
  int          hdr_q[$];
  logic [31:0] ref_d[$];
  logic        ref_s[$];
  logic        ref_e[$];
  logic [31:0] t1 [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_next(input int last, input logic [N_CH-1:0] req);
    for (int k = 1; k <= N_CH; k++) begin
      if (req[(last + k) % N_CH]) return (last + k) % N_CH;
    end
    return -1;
  endfunction

  function automatic logic [31:0] hdr_word(input int c);
    logic [31:0] a;
    a = 32'(ch_addr[c*ADDR_W +: ADDR_W]);
    return (a << 15) | 32'h0000_0AFA;
  endfunction

  task automatic model_word();
    int c;
    logic [31:0] w;
    if (m_pos == 0) begin
      c = rr_next(m_last, p_req);
      if (c < 0) begin
        total++;
        bad++;
        $display("FAIL hdr_no_req: got header %h want no packet", m_data);
        c = 0;
      end
      check("hdr_data", m_data, hdr_word(c));
      check("hdr_sop", m_sop, 1);
      check("hdr_eop", m_eop, 0);
      m_ch = c;
      m_pos = 1;
      m_csum = '0;
      hdr_q.push_back(c);
    end else if (m_pos <= PKT_LEN) begin
      w = src_mem[m_ch][exp_seq[m_ch] % 1024];
      check("data_word", m_data, w);
      check("data_sop", m_sop, 0);
      check("data_eop", m_eop, (m_pos == PKT_LEN) && !TRL);
      exp_seq[m_ch]++;
      m_csum ^= w;
      if (m_pos == PKT_LEN) m_last = m_ch;
      m_pos = (m_pos == PKT_LEN && !TRL) ? 0 : m_pos + 1;
    end else begin
      check("trl_data", m_data, m_csum);
      check("trl_sop", m_sop, 0);
      check("trl_eop", m_eop, 1);
      m_pos = 0;
    end
    cap_d.push_back(m_data);
    cap_s.push_back(m_sop);
    cap_e.push_back(m_eop);
    cap_c.push_back(cyc);
  endtask

  // One clock: observe the previous edge's result, then drive inputs for the next edge.
  task automatic step();
    logic [N_CH-1:0] er;
    @(negedge clk);
    cyc++;
    for (int c = 0; c < N_CH; c++) if (hs[c]) idx[c]++;
    if (p_reset) begin
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_sop", m_sop, 0);
      check("rst_m_eop", m_eop, 0);
      m_last = N_CH - 1;
      m_pos = 0;
      for (int c = 0; c < N_CH; c++) exp_seq[c] = idx[c];
      armed = 1'b1;
    end else if (armed) begin
      if (p_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, p_data);
        check("stall_sop", m_sop, p_sop);
        check("stall_eop", m_eop, p_eop);
      end else if (m_valid === 1'b1) begin
        model_word();
      end else begin
        n_idle++;
      end
    end
    reset = v_reset;
    m_ready = v_ready;
    for (int c = 0; c < N_CH; c++) begin
      s_valid[c] = v_valid[c] && (idx[c] < lim[c]);
      s_data[c*DATA_W +: DATA_W] = src_mem[c][idx[c] % 1024];
    end
    #1;
    if (armed) begin
      er = '0;
      if (m_pos >= 1 && m_pos <= PKT_LEN && (!m_valid || m_ready)) er[m_ch] = 1'b1;
      check("s_ready", 32'(s_ready), 32'(er));
    end
    hs = s_valid & s_ready;
    p_req = s_valid;
    p_reset = !v_reset;
    p_stall = (m_valid === 1'b1) && !v_ready;
    p_data = m_data;
    p_sop = m_sop;
    p_eop = m_eop;
  endtask

  task automatic do_reset(input bit keep, input bit restart);
    v_reset = 1'b0;
    if (!keep) v_valid = '0;
    step();
    if (restart) begin
      for (int c = 0; c < N_CH; c++) idx[c] = 0;
      hs = '0;
    end
    v_reset = 1'b1;
  endtask

  task automatic clear_caps();
    cap_d.delete();
    cap_s.delete();
    cap_e.delete();
    cap_c.delete();
    hdr_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    m_ready = 1'b1;
    s_valid = '0;
    s_data = '0;
    ch_addr = {5'h1F, 5'h11, 5'h03, 5'h0A};
    for (int c = 0; c < N_CH; c++) begin
      for (int i = 0; i < 1024; i++) src_mem[c][i] = $urandom;
      idx[c] = 0;
      lim[c] = 1 << 30;
      exp_seq[c] = 0;
    end
    t1 = '{32'h0001_8AFA, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4};

    // Single channel 1, address 3, data 1..4.
    do_reset(0, 1);
    for (int c = 0; c < N_CH; c++) lim[c] = 0;
    lim[1] = 4;
    for (int i = 0; i < 4; i++) src_mem[1][i] = 32'(i + 1);
    v_valid = 4'b0010;
    clear_caps();
    repeat (10) step();
    check("t1_len", cap_d.size(), PKT_WORDS);
    for (int i = 0; i < PKT_WORDS && i < cap_d.size(); i++) begin
      check("t1_data", cap_d[i], t1[i]);
      check("t1_sop", cap_s[i], i == 0);
      check("t1_eop", cap_e[i], i == PKT_WORDS - 1);
      check("t1_cycle", cap_c[i] - cap_c[0], i);
    end

    // All channels requesting, m_ready=1: grant order and no idle cycles.
    for (int c = 0; c < N_CH; c++) lim[c] = 1 << 30;
    do_reset(0, 1);
    v_valid = 4'hF;
    clear_caps();
    n_idle = 0;
    repeat (5 * PKT_WORDS + 4) step();
    check("t2_hdr_cnt", 32'(hdr_q.size() >= 5), 1);
    for (int i = 0; i < 5 && i < hdr_q.size(); i++) check("t2_grant", hdr_q[i], i % N_CH);
    check("t2_idle", n_idle, 0);
    if (cap_d.size() > 2 * PKT_WORDS) check("t2_hdr_ch2", cap_d[2*PKT_WORDS], 32'h0008_8AFA);
    ref_d = cap_d;
    ref_s = cap_s;
    ref_e = cap_e;

    // Same traffic under random back-pressure must give the same word sequence.
    do_reset(0, 1);
    v_valid = 4'hF;
    clear_caps();
    repeat (100) begin
      v_ready = ($urandom % 2) != 0;
      step();
    end
    v_ready = 1'b1;
    check("t3_len", 32'(cap_d.size() >= 4 * PKT_WORDS), 1);
    for (int i = 0; i < 4 * PKT_WORDS && i < cap_d.size() && i < ref_d.size(); i++) begin
      check("t3_data", cap_d[i], ref_d[i]);
      check("t3_sop", cap_s[i], ref_s[i]);
      check("t3_eop", cap_e[i], ref_e[i]);
    end

    // Channel 2 drops valid for 3 cycles mid-packet.
    do_reset(0, 0);
    v_valid = 4'b1100;
    clear_caps();
    repeat (3) step();
    v_valid = 4'b1000;
    n_idle = 0;
    repeat (3) step();
    v_valid = 4'b1100;
    repeat (10) step();
    check("t4_bubbles", n_idle, 3);
    if (hdr_q.size() > 0) check("t4_first_ch", hdr_q[0], 2);

    // Reset for one cycle while the second data word is transferred.
    do_reset(0, 0);
    v_valid = 4'hF;
    step();
    step();
    v_reset = 1'b0;
    step();
    v_reset = 1'b1;
    hdr_q.delete();
    step();
    step();
    check("t5_hdr_cnt", hdr_q.size(), 1);
    if (hdr_q.size() > 0) check("t5_ch0_first", hdr_q[0], 0);

    // Random valids, random back-pressure, occasional resets.
    do_reset(0, 0);
    repeat (1500) begin
      for (int c = 0; c < N_CH; c++) v_valid[c] = ($urandom % 4) != 0;
      v_ready = ($urandom % 4) != 0;
      if ($urandom % 250 == 0) do_reset(1, 0);
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
